// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the KGP-RISC multi-cycle control unit.
// Holds the state and class enumerations, the opcode map and the mux-select codes.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BR      = 3'd4,
        CLS_JMP     = 3'd5,
        CLS_HALT    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_t;

    localparam int OPC_ALU_R = 0;
    localparam int OPC_ALU_I = 1;
    localparam int OPC_LW    = 2;
    localparam int OPC_SW    = 3;
    localparam int OPC_BR    = 5;
    localparam int OPC_JMP   = 7;
    // -1 truncates to all ones at whatever opcode width the decoder uses
    localparam int OPC_HALT  = -1;

    localparam int ALU_ADD = 0;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction-register, memory-handshake and datapath-control bundle.
// The control unit is the master; the datapath/memory side is the slave.
interface multicycle_control_unit_if #(
    parameter int OPC_W   = 6,
    parameter int FUNC_W  = 5,
    parameter int ALUOP_W = 5
);
    logic [OPC_W-1:0]   opcode;
    logic [FUNC_W-1:0]  func;
    logic               mem_ack;

    logic               mem_req;
    logic               mem_ifetch;
    logic               irWrite;
    logic               pcWrite;
    logic [1:0]         regDst;
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic [1:0]         memToReg;
    logic               ALUsrc;
    logic [ALUOP_W-1:0] ALUop;
    logic               ALUsel;
    logic               branch;
    logic               jumpAddr;
    logic               lblSel;

    modport master (
        input  opcode, func, mem_ack,
        output mem_req, mem_ifetch, irWrite, pcWrite, regDst, regWrite,
               memRead, memWrite, memToReg, ALUsrc, ALUop, ALUsel,
               branch, jumpAddr, lblSel
    );

    modport slave (
        output opcode, func, mem_ack,
        input  mem_req, mem_ifetch, irWrite, pcWrite, regDst, regWrite,
               memRead, memWrite, memToReg, ALUsrc, ALUop, ALUsel,
               branch, jumpAddr, lblSel
    );
endinterface

// File: rtl/multicycle_control_unit_ctrl_decoder.sv
// Combinational opcode/func decoder: instruction class plus the steering fields
// that the FSM captures during DECODE.
module ctrl_decoder
    import kgp_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int FUNC_W  = 5,
    parameter int ALUOP_W = 5
) (
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [FUNC_W-1:0]  func_i,
    output cls_t               cls_o,
    output logic [1:0]         regDst_o,
    output logic [1:0]         memToReg_o,
    output logic               aluSrc_o,
    output logic [ALUOP_W-1:0] aluOp_o,
    output logic               aluSel_o,
    output logic               branch_o,
    output logic               jumpAddr_o,
    output logic               lblSel_o,
    output logic               link_o
);

    always_comb begin
        cls_o      = CLS_ILLEGAL;
        regDst_o   = REGDST_RT;
        memToReg_o = M2R_ALU;
        aluSrc_o   = 1'b0;
        aluOp_o    = ALUOP_W'(ALU_ADD);
        aluSel_o   = 1'b0;
        branch_o   = 1'b0;
        jumpAddr_o = 1'b0;
        lblSel_o   = 1'b0;
        link_o     = 1'b0;

        // HALT is tested first so it wins if a narrow opcode aliases another class
        if (opcode_i == OPC_W'(OPC_HALT)) begin
            cls_o = CLS_HALT;
        end else begin
            case (opcode_i)
                OPC_W'(OPC_ALU_R): begin
                    cls_o    = CLS_ALU_R;
                    aluOp_o  = ALUOP_W'(func_i);
                    regDst_o = REGDST_RD;
                end
                OPC_W'(OPC_ALU_I): begin
                    cls_o    = CLS_ALU_I;
                    aluOp_o  = ALUOP_W'(func_i);
                    aluSrc_o = 1'b1;
                end
                OPC_W'(OPC_LW): begin
                    cls_o      = CLS_LW;
                    aluSrc_o   = 1'b1;
                    memToReg_o = M2R_MEM;
                end
                OPC_W'(OPC_SW): begin
                    cls_o    = CLS_SW;
                    aluSrc_o = 1'b1;
                end
                OPC_W'(OPC_BR): begin
                    cls_o    = CLS_BR;
                    aluSel_o = 1'b1;
                    branch_o = 1'b1;
                    aluOp_o  = ALUOP_W'(func_i);
                end
                OPC_W'(OPC_JMP): begin
                    cls_o      = CLS_JMP;
                    jumpAddr_o = 1'b1;
                    lblSel_o   = 1'b1;
                    link_o     = func_i[0];
                    if (func_i[0]) begin
                        regDst_o   = REGDST_RA;
                        memToReg_o = M2R_PC;
                    end
                end
                default: cls_o = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle KGP-RISC control unit: FETCH/DECODE/EXEC/MEM/WB sequencer over a shared memory.
// Define MCU_PERF_CNT_EN to build the instruction and cycle performance counters.
module multicycle_control_unit
    import kgp_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int FUNC_W  = 5,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_unit_if.master bus,
    output logic                      illegal,
    output logic                      halted,
    output logic [2:0]                state_o,
    output logic [CNT_W-1:0]          instr_cnt,
    output logic [CNT_W-1:0]          cycle_cnt
);

    state_t             state_q, state_d;
    cls_t               cls_q;
    logic [1:0]         regDst_q, memToReg_q;
    logic               aluSrc_q, aluSel_q, branch_q, jumpAddr_q, lblSel_q, link_q;
    logic [ALUOP_W-1:0] aluOp_q;

    cls_t               decCls;
    logic [1:0]         decRegDst, decMemToReg;
    logic               decAluSrc, decAluSel, decBranch, decJumpAddr, decLblSel, decLink;
    logic [ALUOP_W-1:0] decAluOp;

    ctrl_decoder #(
        .OPC_W   (OPC_W),
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W)
    ) u_decoder (
        .opcode_i   (bus.opcode),
        .func_i     (bus.func),
        .cls_o      (decCls),
        .regDst_o   (decRegDst),
        .memToReg_o (decMemToReg),
        .aluSrc_o   (decAluSrc),
        .aluOp_o    (decAluOp),
        .aluSel_o   (decAluSel),
        .branch_o   (decBranch),
        .jumpAddr_o (decJumpAddr),
        .lblSel_o   (decLblSel),
        .link_o     (decLink)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (bus.mem_ack) state_d = ST_DECODE;
            ST_DECODE: begin
                case (decCls)
                    CLS_HALT:    state_d = ST_HALT;
                    CLS_ILLEGAL: state_d = ST_FETCH;
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    CLS_BR:         state_d = ST_FETCH;
                    CLS_JMP: begin
                        if (link_q) state_d = ST_WB;
                        else        state_d = ST_FETCH;
                    end
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    if (cls_q == CLS_LW) state_d = ST_WB;
                    else                 state_d = ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoder result is captured only in DECODE, so IR changes elsewhere cannot leak in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cls_q      <= CLS_ALU_R;
            regDst_q   <= 2'b00;
            memToReg_q <= 2'b00;
            aluSrc_q   <= 1'b0;
            aluOp_q    <= '0;
            aluSel_q   <= 1'b0;
            branch_q   <= 1'b0;
            jumpAddr_q <= 1'b0;
            lblSel_q   <= 1'b0;
            link_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q      <= decCls;
                regDst_q   <= decRegDst;
                memToReg_q <= decMemToReg;
                aluSrc_q   <= decAluSrc;
                aluOp_q    <= decAluOp;
                aluSel_q   <= decAluSel;
                branch_q   <= decBranch;
                jumpAddr_q <= decJumpAddr;
                lblSel_q   <= decLblSel;
                link_q     <= decLink;
            end
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_ifetch = 1'b0;
        bus.irWrite    = 1'b0;
        bus.pcWrite    = 1'b0;
        bus.regWrite   = 1'b0;
        bus.memRead    = 1'b0;
        bus.memWrite   = 1'b0;
        bus.branch     = 1'b0;
        bus.jumpAddr   = 1'b0;
        bus.regDst     = 2'b00;
        bus.memToReg   = 2'b00;
        bus.ALUsrc     = 1'b0;
        bus.ALUop      = '0;
        bus.ALUsel     = 1'b0;
        bus.lblSel     = 1'b0;
        illegal        = 1'b0;
        halted         = 1'b0;

        case (state_q)
            ST_FETCH: begin
                bus.mem_req    = 1'b1;
                bus.mem_ifetch = 1'b1;
                bus.irWrite    = bus.mem_ack;
                bus.pcWrite    = bus.mem_ack;
            end
            ST_DECODE: illegal = (decCls == CLS_ILLEGAL);
            ST_EXEC: begin
                bus.pcWrite  = (cls_q == CLS_BR) || (cls_q == CLS_JMP);
                bus.branch   = branch_q;
                bus.jumpAddr = jumpAddr_q;
            end
            ST_MEM: begin
                bus.mem_req  = 1'b1;
                bus.memRead  = (cls_q == CLS_LW);
                bus.memWrite = (cls_q == CLS_SW);
            end
            ST_WB:   bus.regWrite = 1'b1;
            ST_HALT: halted = 1'b1;
            default: ;
        endcase

        // Steering fields follow the latched instruction from EXEC to its last cycle
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            bus.regDst   = regDst_q;
            bus.memToReg = memToReg_q;
            bus.ALUsrc   = aluSrc_q;
            bus.ALUop    = aluOp_q;
            bus.ALUsel   = aluSel_q;
            bus.lblSel   = lblSel_q;
        end
    end

    assign state_o = state_q;

`ifdef MCU_PERF_CNT_EN
    logic [CNT_W-1:0] instrCnt_q, cycleCnt_q;
    logic             retire;

    // Retire on the step back to FETCH after a defined instruction, and on entering HALT
    assign retire = ((state_d == ST_FETCH) &&
                     (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB)) ||
                    ((state_d == ST_HALT) && (state_q == ST_DECODE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrCnt_q <= '0;
            cycleCnt_q <= '0;
        end else begin
            if (state_q != ST_IDLE && state_q != ST_HALT)
                cycleCnt_q <= cycleCnt_q + CNT_W'(1);
            if (retire)
                instrCnt_q <= instrCnt_q + CNT_W'(1);
        end
    end

    assign instr_cnt = instrCnt_q;
    assign cycle_cnt = cycleCnt_q;
`else
    assign instr_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expectations go through a
// scoreboard queue and are compared at the falling edge.
module tb_multicycle_control_unit;

    localparam int OPC_W   = 6;
    localparam int FUNC_W  = 5;
    localparam int ALUOP_W = 5;
    localparam int CNT_W   = 32;

    localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3,
                           SM = 3'd4, SB = 3'd5, SH = 3'd6;

    localparam logic [13:0] REQ = 14'h0001, IFT = 14'h0002, IRW = 14'h0004,
                            PCW = 14'h0008, RW  = 14'h0010, MR  = 14'h0020,
                            MW  = 14'h0040, BRN = 14'h0080, JA  = 14'h0100,
                            LBL = 14'h0200, SEL = 14'h0400, SRC = 14'h0800,
                            ILL = 14'h1000, HLT = 14'h2000;
    localparam logic [13:0] FOK = REQ | IFT | IRW | PCW;

`ifdef MCU_PERF_CNT_EN
    localparam logic [CNT_W-1:0] EXP_INSTR = 32'd3;
    localparam logic [CNT_W-1:0] EXP_CYCLE = 32'd10;
`else
    localparam logic [CNT_W-1:0] EXP_INSTR = 32'd0;
    localparam logic [CNT_W-1:0] EXP_CYCLE = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             illegal, halted;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instr_cnt, cycle_cnt;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OPC_W(OPC_W), .FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W)) bus();

    multicycle_control_unit #(
        .OPC_W(OPC_W), .FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .illegal   (illegal),
        .halted    (halted),
        .state_o   (state_o),
        .instr_cnt (instr_cnt),
        .cycle_cnt (cycle_cnt)
    );

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [22:0] ctl;
    } exp_t;

    exp_t scoreboard[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [22:0] obsCtl();
        return {halted, illegal, bus.ALUsrc, bus.ALUsel, bus.lblSel, bus.jumpAddr,
                bus.branch, bus.memWrite, bus.memRead, bus.regWrite, bus.pcWrite,
                bus.irWrite, bus.mem_ifetch, bus.mem_req,
                bus.regDst, bus.memToReg, bus.ALUop};
    endfunction

    task automatic checkOutput();
        exp_t        e;
        logic [22:0] got;
        checks++;
        assert (scoreboard.size() > 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_underflow observed=0 expected=1");
        end
        if (scoreboard.size() == 0) return;
        e   = scoreboard.pop_front();
        got = obsCtl();
        checks++;
        assert (state_o === e.st) else begin
            failures++;
            $error("[TB] FAIL %s.state observed=%0d expected=%0d", e.tag, state_o, e.st);
        end
        checks++;
        assert (got === e.ctl) else begin
            failures++;
            $error("[TB] FAIL %s.ctl observed=%h expected=%h", e.tag, got, e.ctl);
        end
    endtask

    task automatic pushExp(input string tag, input logic [2:0] st, input logic [13:0] fl,
                           input logic [1:0] rd, input logic [1:0] m2r, input logic [4:0] aop);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ctl = {fl, rd, m2r, aop};
        scoreboard.push_back(e);
    endtask

    // One clock cycle: drive IR/ack, queue the expectation, compare at the falling edge
    task automatic applyStimulus(input string tag, input logic ack, input logic [5:0] opc,
                                 input logic [4:0] fn, input logic [2:0] st,
                                 input logic [13:0] fl, input logic [1:0] rd,
                                 input logic [1:0] m2r, input logic [4:0] aop);
        bus.mem_ack = ack;
        bus.opcode  = opc;
        bus.func    = fn;
        pushExp(tag, st, fl, rd, m2r, aop);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag, input logic [CNT_W-1:0] expInstr,
                                 input logic [CNT_W-1:0] expCycle);
        checks++;
        assert (instr_cnt === expInstr) else begin
            failures++;
            $error("[TB] FAIL %s.instr_cnt observed=%0d expected=%0d", tag, instr_cnt, expInstr);
        end
        checks++;
        assert (cycle_cnt === expCycle) else begin
            failures++;
            $error("[TB] FAIL %s.cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, expCycle);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.mem_ack = 1'b0;
        bus.opcode  = '0;
        bus.func    = '0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset", 1, 6'h3F, 5'h1F, SI, 14'h0, 2'b00, 2'b00, 5'h00);
        checkCounters("reset", '0, '0);
        rst = 1'b0;

        // ALU_R, with the IR changed to junk after DECODE
        applyStimulus("aluR.idle",   1, 6'h00, 5'h03, SI, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("aluR.fetch",  1, 6'h00, 5'h03, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("aluR.decode", 1, 6'h00, 5'h03, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("aluR.exec",   1, 6'h04, 5'h1C, SE, 14'h0, 2'b01, 2'b00, 5'h03);
        applyStimulus("aluR.wb",     1, 6'h04, 5'h1C, SB, RW,    2'b01, 2'b00, 5'h03);

        // LW with three memory wait cycles
        applyStimulus("lw.fetch",  1, 6'h02, 5'h15, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("lw.decode", 1, 6'h02, 5'h15, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("lw.exec",   1, 6'h00, 5'h00, SE, SRC,   2'b00, 2'b01, 5'h00);
        for (int i = 0; i < 3; i++)
            applyStimulus("lw.memWait", 0, 6'h00, 5'h00, SM, REQ | MR | SRC, 2'b00, 2'b01, 5'h00);
        applyStimulus("lw.memAck", 1, 6'h00, 5'h00, SM, REQ | MR | SRC, 2'b00, 2'b01, 5'h00);
        applyStimulus("lw.wb",     0, 6'h00, 5'h00, SB, RW | SRC,       2'b00, 2'b01, 5'h00);

        // JMP with link
        applyStimulus("jal.fetch",  1, 6'h07, 5'h01, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("jal.decode", 1, 6'h07, 5'h01, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("jal.exec",   1, 6'h07, 5'h01, SE, PCW | JA | LBL, 2'b10, 2'b10, 5'h00);
        applyStimulus("jal.wb",     1, 6'h07, 5'h01, SB, RW | LBL,       2'b10, 2'b10, 5'h00);

        // plain JMP
        applyStimulus("jmp.fetch",  1, 6'h07, 5'h00, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("jmp.decode", 1, 6'h07, 5'h00, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("jmp.exec",   1, 6'h07, 5'h00, SE, PCW | JA | LBL, 2'b00, 2'b00, 5'h00);

        // BR
        applyStimulus("br.fetch",  1, 6'h05, 5'h06, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("br.decode", 1, 6'h05, 5'h06, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("br.exec",   1, 6'h05, 5'h06, SE, PCW | BRN | SEL, 2'b00, 2'b00, 5'h06);

        // ALU_I with one fetch wait cycle
        applyStimulus("aluI.fetchWait", 0, 6'h01, 5'h1F, SF, REQ | IFT, 2'b00, 2'b00, 5'h00);
        applyStimulus("aluI.fetch",     1, 6'h01, 5'h1F, SF, FOK,       2'b00, 2'b00, 5'h00);
        applyStimulus("aluI.decode",    1, 6'h01, 5'h1F, SD, 14'h0,     2'b00, 2'b00, 5'h00);
        applyStimulus("aluI.exec",      1, 6'h01, 5'h1F, SE, SRC,       2'b00, 2'b00, 5'h1F);
        applyStimulus("aluI.wb",        1, 6'h01, 5'h1F, SB, RW | SRC,  2'b00, 2'b00, 5'h1F);

        // undefined opcode: illegal pulse, then straight back to FETCH
        applyStimulus("ill.fetch",  1, 6'h04, 5'h00, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("ill.decode", 1, 6'h04, 5'h00, SD, ILL,   2'b00, 2'b00, 5'h00);

        // SW completes normally
        applyStimulus("sw.fetch",  1, 6'h03, 5'h00, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("sw.decode", 1, 6'h03, 5'h00, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("sw.exec",   1, 6'h03, 5'h00, SE, SRC,   2'b00, 2'b00, 5'h00);
        applyStimulus("sw.mem",    1, 6'h03, 5'h00, SM, REQ | MW | SRC, 2'b00, 2'b00, 5'h00);

        // SW aborted by reset while waiting in MEM
        applyStimulus("swRst.fetch",  1, 6'h03, 5'h00, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("swRst.decode", 1, 6'h03, 5'h00, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("swRst.exec",   0, 6'h03, 5'h00, SE, SRC,   2'b00, 2'b00, 5'h00);
        applyStimulus("swRst.mem",    0, 6'h03, 5'h00, SM, REQ | MW | SRC, 2'b00, 2'b00, 5'h00);
        rst = 1'b1;
        #1;
        pushExp("swRst.async", SI, 14'h0, 2'b00, 2'b00, 5'h00);
        checkOutput();
        checkCounters("swRst.async", '0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU_R, SW, HALT from a clean reset for the counters
        applyStimulus("cnt.idle",        1, 6'h00, 5'h02, SI, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("cnt.aluR.fetch",  1, 6'h00, 5'h02, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("cnt.aluR.decode", 1, 6'h00, 5'h02, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("cnt.aluR.exec",   1, 6'h00, 5'h02, SE, 14'h0, 2'b01, 2'b00, 5'h02);
        applyStimulus("cnt.aluR.wb",     1, 6'h00, 5'h02, SB, RW,    2'b01, 2'b00, 5'h02);
        applyStimulus("cnt.sw.fetch",    1, 6'h03, 5'h00, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("cnt.sw.decode",   1, 6'h03, 5'h00, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("cnt.sw.exec",     1, 6'h03, 5'h00, SE, SRC,   2'b00, 2'b00, 5'h00);
        applyStimulus("cnt.sw.mem",      1, 6'h03, 5'h00, SM, REQ | MW | SRC, 2'b00, 2'b00, 5'h00);
        applyStimulus("halt.fetch",      1, 6'h3F, 5'h00, SF, FOK,   2'b00, 2'b00, 5'h00);
        applyStimulus("halt.decode",     1, 6'h3F, 5'h00, SD, 14'h0, 2'b00, 2'b00, 5'h00);
        applyStimulus("halt.enter",      1, 6'h00, 5'h03, SH, HLT,   2'b00, 2'b00, 5'h00);
        checkCounters("halt.enter", EXP_INSTR, EXP_CYCLE);
        applyStimulus("halt.hold1",      1, 6'h01, 5'h1F, SH, HLT,   2'b00, 2'b00, 5'h00);
        applyStimulus("halt.hold2",      0, 6'h07, 5'h01, SH, HLT,   2'b00, 2'b00, 5'h00);
        checkCounters("halt.hold", EXP_INSTR, EXP_CYCLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
